// File: rtl/ras_repair_pkg.sv
// Shared fetch RAS configuration and repair sequencer state encoding.
// Used by the commit stack, the repair FSM and the fetch-stage RAS.
package ras_repair_pkg;

    localparam int CFG_SIZE_PC      = 32;
    localparam int CFG_SIZE_RAS     = 16;
    localparam int CFG_SIZE_RAS_LOG = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        COPY = 2'd1,
        DONE = 2'd2
    } repair_state_e;

    // Return address is the slot after the call and its delay slot.
    function automatic logic [CFG_SIZE_PC-1:0] ret_addr(
        input logic [CFG_SIZE_PC-1:0] pc
    );
        return pc + CFG_SIZE_PC'(8);
    endfunction

endpackage

// File: rtl/ras_repair_if.sv
// Retire-side commit inputs and write-only repair port toward the fetch RAS.
// master is the repair sequencer side, slave is the retire/fetch side.
interface ras_repair_if #(
    parameter int SIZE_PC      = ras_repair_pkg::CFG_SIZE_PC,
    parameter int SIZE_RAS_LOG = ras_repair_pkg::CFG_SIZE_RAS_LOG
);

    logic                    stall_i;
    logic                    commitValid_i;
    logic                    commitCall_i;
    logic                    commitRtr_i;
    logic [SIZE_PC-1:0]      commitPC_i;
    logic                    flagRecoverEX_i;

    logic                    repairValid_o;
    logic [SIZE_RAS_LOG-1:0] repairIdx_o;
    logic [SIZE_PC-1:0]      repairAddr_o;
    logic                    repairTosValid_o;
    logic [SIZE_RAS_LOG-1:0] repairTos_o;
    logic                    repairDone_o;
    logic                    busy_o;

    modport master (
        input  stall_i,
        input  commitValid_i,
        input  commitCall_i,
        input  commitRtr_i,
        input  commitPC_i,
        input  flagRecoverEX_i,
        output repairValid_o,
        output repairIdx_o,
        output repairAddr_o,
        output repairTosValid_o,
        output repairTos_o,
        output repairDone_o,
        output busy_o
    );

    modport slave (
        output stall_i,
        output commitValid_i,
        output commitCall_i,
        output commitRtr_i,
        output commitPC_i,
        output flagRecoverEX_i,
        input  repairValid_o,
        input  repairIdx_o,
        input  repairAddr_o,
        input  repairTosValid_o,
        input  repairTos_o,
        input  repairDone_o,
        input  busy_o
    );

endinterface

// File: rtl/ras_commit_stack.sv
// Committed (architectural) return address stack: circular LIFO updated
// by retiring calls/returns, with a combinational read port for repair.
module ras_commit_stack
    import ras_repair_pkg::*;
#(
    parameter int SIZE_PC      = CFG_SIZE_PC,
    parameter int SIZE_RAS     = CFG_SIZE_RAS,
    parameter int SIZE_RAS_LOG = CFG_SIZE_RAS_LOG
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    commit_valid_i,
    input  logic                    commit_call_i,
    input  logic                    commit_rtr_i,
    input  logic [SIZE_PC-1:0]      commit_pc_i,
    input  logic [SIZE_RAS_LOG-1:0] rd_idx_i,
    output logic [SIZE_PC-1:0]      rd_data_o,
    output logic [SIZE_RAS_LOG-1:0] ctos_o,
    output logic                    update_o
);

    logic [SIZE_RAS_LOG-1:0] ctos_q;
    logic [SIZE_RAS_LOG-1:0] ctos_d;
    logic [SIZE_PC-1:0]      cstack_q [SIZE_RAS];
    logic [SIZE_PC-1:0]      cstack_d [SIZE_RAS];
    logic [SIZE_RAS_LOG-1:0] ctos_inc;
    logic [SIZE_RAS_LOG-1:0] ctos_dec;
    logic [SIZE_PC-1:0]      ret_pc;

    assign ctos_inc = ctos_q + SIZE_RAS_LOG'(1);
    assign ctos_dec = ctos_q - SIZE_RAS_LOG'(1);
    assign ret_pc   = commit_pc_i + SIZE_PC'(8);

    always_comb begin
        ctos_d   = ctos_q;
        cstack_d = cstack_q;
        if (commit_valid_i) begin
            unique case ({commit_call_i, commit_rtr_i})
                2'b10: begin
                    ctos_d           = ctos_inc;
                    cstack_d[ctos_inc] = ret_pc;
                end
                2'b01: ctos_d = ctos_dec;
                // Call+return replaces the top entry in place.
                2'b11: cstack_d[ctos_q] = ret_pc;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ctos_q <= '0;
            for (int i = 0; i < SIZE_RAS; i++) begin
                cstack_q[i] <= '0;
            end
        end else begin
            ctos_q   <= ctos_d;
            cstack_q <= cstack_d;
        end
    end

    assign rd_data_o = cstack_q[rd_idx_i];
    assign ctos_o    = ctos_q;
    assign update_o  = commit_valid_i & (commit_call_i | commit_rtr_i);

endmodule

// File: rtl/ras_repair.sv
// Repair sequencer: on recovery, streams the committed stack and its top
// pointer into the speculative fetch RAS one slot per cycle.
module ras_repair
    import ras_repair_pkg::*;
#(
    parameter int SIZE_PC      = CFG_SIZE_PC,
    parameter int SIZE_RAS     = CFG_SIZE_RAS,
    parameter int SIZE_RAS_LOG = CFG_SIZE_RAS_LOG
) (
    input logic          clk,
    input logic          reset,
    ras_repair_if.master rif
);

    localparam logic [SIZE_RAS_LOG-1:0] LAST_IDX = SIZE_RAS_LOG'(SIZE_RAS - 1);

    repair_state_e           state_q;
    repair_state_e           state_d;
    logic [SIZE_RAS_LOG-1:0] idx_q;
    logic [SIZE_RAS_LOG-1:0] idx_d;
    logic [SIZE_PC-1:0]      rd_data;
    logic [SIZE_RAS_LOG-1:0] ctos;
    logic                    stack_update;

    ras_commit_stack #(
        .SIZE_PC      (SIZE_PC),
        .SIZE_RAS     (SIZE_RAS),
        .SIZE_RAS_LOG (SIZE_RAS_LOG)
    ) u_stack (
        .clk            (clk),
        .reset          (reset),
        .commit_valid_i (rif.commitValid_i),
        .commit_call_i  (rif.commitCall_i),
        .commit_rtr_i   (rif.commitRtr_i),
        .commit_pc_i    (rif.commitPC_i),
        .rd_idx_i       (idx_q),
        .rd_data_o      (rd_data),
        .ctos_o         (ctos),
        .update_o       (stack_update)
    );

    always_comb begin
        state_d              = state_q;
        idx_d                = idx_q;
        rif.repairValid_o    = 1'b0;
        rif.repairIdx_o      = '0;
        rif.repairAddr_o     = '0;
        rif.repairTosValid_o = 1'b0;
        rif.repairTos_o      = '0;
        rif.repairDone_o     = 1'b0;
        rif.busy_o           = (state_q != IDLE);
        unique case (state_q)
            IDLE: begin
                if (rif.flagRecoverEX_i) begin
                    state_d = COPY;
                    idx_d   = '0;
                end
            end
            COPY: begin
                if (!rif.stall_i) begin
                    rif.repairValid_o = 1'b1;
                    rif.repairIdx_o   = idx_q;
                    rif.repairAddr_o  = rd_data;
                    if (idx_q == LAST_IDX) begin
                        rif.repairTosValid_o = 1'b1;
                        rif.repairTos_o      = ctos;
                        state_d              = DONE;
                    end else begin
                        idx_d = idx_q + SIZE_RAS_LOG'(1);
                    end
                end
                // A new recovery or a stack change invalidates the snapshot.
                if (rif.flagRecoverEX_i || stack_update) begin
                    state_d = COPY;
                    idx_d   = '0;
                end
            end
            DONE: begin
                rif.repairDone_o = 1'b1;
                state_d          = IDLE;
                if (rif.flagRecoverEX_i) begin
                    state_d = COPY;
                    idx_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

endmodule

// File: tb/tb_ras_repair.sv
// Self-checking bench for ras_repair: directed scenarios plus randomized
// commit/recover/stall traffic against a behavioural LIFO model.
module tb_ras_repair;

    logic clk;
    logic rst;

    int n_chk;
    int n_pass;

    logic [31:0] m_stk [16];
    logic [3:0]  m_tos;

    ras_repair_if #(.SIZE_PC(32), .SIZE_RAS_LOG(4)) rif ();

    ras_repair #(
        .SIZE_PC      (32),
        .SIZE_RAS     (16),
        .SIZE_RAS_LOG (4)
    ) dut (
        .clk   (clk),
        .reset (rst),
        .rif   (rif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [43:0] ev(bit v, logic [3:0] i, logic [31:0] a,
                                       bit tv, logic [3:0] t, bit d, bit b);
        return {v, i, a, tv, t, d, b};
    endfunction

    function automatic logic [43:0] ov();
        return {rif.repairValid_o, rif.repairIdx_o, rif.repairAddr_o,
                rif.repairTosValid_o, rif.repairTos_o, rif.repairDone_o,
                rif.busy_o};
    endfunction

    task automatic model_commit(bit c, bit r, logic [31:0] pc);
        if (c && !r) begin
            m_tos = m_tos + 4'd1;
            m_stk[m_tos] = pc + 32'd8;
        end else if (!c && r) begin
            m_tos = m_tos - 4'd1;
        end else if (c && r) begin
            m_stk[m_tos] = pc + 32'd8;
        end
    endtask

    task automatic step();
        if (rst) begin
            for (int i = 0; i < 16; i++) m_stk[i] = 32'd0;
            m_tos = 4'd0;
        end else if (rif.commitValid_i) begin
            model_commit(rif.commitCall_i, rif.commitRtr_i, rif.commitPC_i);
        end
        @(posedge clk);
        #1;
        rif.commitValid_i   = 1'b0;
        rif.commitCall_i    = 1'b0;
        rif.commitRtr_i     = 1'b0;
        rif.commitPC_i      = 32'd0;
        rif.flagRecoverEX_i = 1'b0;
    endtask

    task automatic do_call(logic [31:0] pc, bit c, bit r);
        rif.commitValid_i = 1'b1;
        rif.commitCall_i  = c;
        rif.commitRtr_i   = r;
        rif.commitPC_i    = pc;
    endtask

    task automatic test_reset();
        logic [43:0] e;
        rst = 1'b1;
        step();
        step();
        #1;
        e = ev(0, 0, 0, 0, 0, 0, 0);
        n_chk++;
        if (ov() !== e) $display("FAIL reset got=%h exp=%h", ov(), e);
        else n_pass++;
        rst = 1'b0;
        step();
        #1;
        n_chk++;
        if (ov() !== e) $display("FAIL reset_release got=%h exp=%h", ov(), e);
        else n_pass++;
        step();
    endtask

    task automatic test_three_calls();
        logic [43:0] e;
        for (int j = 1; j <= 3; j++) begin
            do_call(32'h100 * j, 1, 0);
            step();
        end
        rif.flagRecoverEX_i = 1'b1;
        #1;
        e = ev(0, 0, 0, 0, 0, 0, 0);
        n_chk++;
        if (ov() !== e) $display("FAIL calls_pulse got=%h exp=%h", ov(), e);
        else n_pass++;
        step();
        for (int k = 0; k < 16; k++) begin
            #1;
            e = ev(1, 4'(k), m_stk[k], k == 15, (k == 15) ? m_tos : 4'd0, 0, 1);
            n_chk++;
            if (ov() !== e) $display("FAIL calls_write k=%0d got=%h exp=%h", k, ov(), e);
            else n_pass++;
            step();
        end
        #1;
        e = ev(0, 0, 0, 0, 0, 1, 1);
        n_chk++;
        if (ov() !== e) $display("FAIL calls_done got=%h exp=%h", ov(), e);
        else n_pass++;
        step();
        #1;
        e = ev(0, 0, 0, 0, 0, 0, 0);
        n_chk++;
        if (ov() !== e) $display("FAIL calls_idle got=%h exp=%h", ov(), e);
        else n_pass++;
        step();
    endtask

    task automatic test_wrap();
        logic [43:0] e;
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int k = 0; k <= 16; k++) begin
            do_call(32'h1000 + 32'(16 * k), 1, 0);
            step();
        end
        do_call(32'h0, 0, 1);
        step();
        rif.flagRecoverEX_i = 1'b1;
        step();
        for (int k = 0; k < 16; k++) begin
            #1;
            e = ev(1, 4'(k), m_stk[k], k == 15, (k == 15) ? m_tos : 4'd0, 0, 1);
            n_chk++;
            if (ov() !== e) $display("FAIL wrap_write k=%0d got=%h exp=%h", k, ov(), e);
            else n_pass++;
            if (k == 1) begin
                n_chk++;
                if (rif.repairAddr_o !== 32'h1108)
                    $display("FAIL wrap_slot1 got=%h exp=%h", rif.repairAddr_o, 32'h1108);
                else n_pass++;
            end
            if (k == 15) begin
                n_chk++;
                if (rif.repairTos_o !== 4'd0)
                    $display("FAIL wrap_tos got=%h exp=0", rif.repairTos_o);
                else n_pass++;
            end
            step();
        end
        #1;
        e = ev(0, 0, 0, 0, 0, 1, 1);
        n_chk++;
        if (ov() !== e) $display("FAIL wrap_done got=%h exp=%h", ov(), e);
        else n_pass++;
        step();
    endtask

    task automatic test_stall();
        logic [43:0] e;
        int k;
        int c;
        rif.flagRecoverEX_i = 1'b1;
        step();
        k = 0;
        c = 0;
        while (k < 16 && c < 40) begin
            rif.stall_i = (c >= 3 && c <= 5);
            #1;
            if (rif.stall_i) e = ev(0, 0, 0, 0, 0, 0, 1);
            else e = ev(1, 4'(k), m_stk[k], k == 15, (k == 15) ? m_tos : 4'd0, 0, 1);
            n_chk++;
            if (ov() !== e) $display("FAIL stall_cyc c=%0d got=%h exp=%h", c, ov(), e);
            else n_pass++;
            if (!rif.stall_i) k++;
            step();
            c++;
        end
        rif.stall_i = 1'b0;
        #1;
        e = ev(0, 0, 0, 0, 0, 1, 1);
        n_chk++;
        if (ov() !== e) $display("FAIL stall_done got=%h exp=%h", ov(), e);
        else n_pass++;
        step();
    endtask

    task automatic test_commit_restart();
        logic [43:0] e;
        int writes;
        rst = 1'b1;
        step();
        rst = 1'b0;
        writes = 0;
        rif.flagRecoverEX_i = 1'b1;
        step();
        for (int k = 0; k < 8; k++) begin
            if (k == 7) do_call(32'h400, 1, 0);
            #1;
            e = ev(1, 4'(k), m_stk[k], 0, 0, 0, 1);
            n_chk++;
            if (ov() !== e) $display("FAIL restart_pre k=%0d got=%h exp=%h", k, ov(), e);
            else n_pass++;
            if (rif.repairValid_o === 1'b1) writes++;
            step();
        end
        for (int k = 0; k < 16; k++) begin
            #1;
            e = ev(1, 4'(k), m_stk[k], k == 15, (k == 15) ? m_tos : 4'd0, 0, 1);
            n_chk++;
            if (ov() !== e) $display("FAIL restart_post k=%0d got=%h exp=%h", k, ov(), e);
            else n_pass++;
            if (rif.repairValid_o === 1'b1) writes++;
            step();
        end
        #1;
        e = ev(0, 0, 0, 0, 0, 1, 1);
        n_chk++;
        if (ov() !== e) $display("FAIL restart_done got=%h exp=%h", ov(), e);
        else n_pass++;
        n_chk++;
        if (writes != 24) $display("FAIL restart_writes got=%0d exp=24", writes);
        else n_pass++;
        step();
    endtask

    task automatic test_recover_in_done();
        logic [43:0] e;
        rif.flagRecoverEX_i = 1'b1;
        step();
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 16; k++) begin
                #1;
                e = ev(1, 4'(k), m_stk[k], k == 15, (k == 15) ? m_tos : 4'd0, 0, 1);
                n_chk++;
                if (ov() !== e) $display("FAIL rdone_write r=%0d k=%0d got=%h exp=%h", r, k, ov(), e);
                else n_pass++;
                step();
            end
            if (r == 0) rif.flagRecoverEX_i = 1'b1;
            #1;
            e = ev(0, 0, 0, 0, 0, 1, 1);
            n_chk++;
            if (ov() !== e) $display("FAIL rdone_done r=%0d got=%h exp=%h", r, ov(), e);
            else n_pass++;
            step();
        end
        #1;
        e = ev(0, 0, 0, 0, 0, 0, 0);
        n_chk++;
        if (ov() !== e) $display("FAIL rdone_idle got=%h exp=%h", ov(), e);
        else n_pass++;
        step();
    endtask

    task automatic test_reset_mid();
        logic [43:0] e;
        do_call(32'h500, 1, 0);
        step();
        rif.flagRecoverEX_i = 1'b1;
        step();
        for (int k = 0; k <= 5; k++) begin
            if (k == 5) rst = 1'b1;
            #1;
            e = ev(1, 4'(k), m_stk[k], 0, 0, 0, 1);
            n_chk++;
            if (ov() !== e) $display("FAIL rmid_write k=%0d got=%h exp=%h", k, ov(), e);
            else n_pass++;
            step();
        end
        rst = 1'b0;
        #1;
        e = ev(0, 0, 0, 0, 0, 0, 0);
        n_chk++;
        if (ov() !== e) $display("FAIL rmid_after got=%h exp=%h", ov(), e);
        else n_pass++;
        rif.flagRecoverEX_i = 1'b1;
        step();
        for (int k = 0; k < 16; k++) begin
            #1;
            e = ev(1, 4'(k), 32'd0, k == 15, 4'd0, 0, 1);
            n_chk++;
            if (ov() !== e) $display("FAIL rmid_zero k=%0d got=%h exp=%h", k, ov(), e);
            else n_pass++;
            step();
        end
        step();
    endtask

    task automatic test_random();
        logic [43:0] e;
        int n;
        int k;
        int c;
        for (int r = 0; r < 10; r++) begin
            n = $urandom_range(1, 20);
            for (int j = 0; j < n; j++) begin
                do_call($urandom, 1'($urandom % 2), 1'($urandom % 2));
                if (j == n - 1) rif.flagRecoverEX_i = 1'b1;
                #1;
                e = ev(0, 0, 0, 0, 0, 0, 0);
                n_chk++;
                if (ov() !== e) $display("FAIL rand_idle r=%0d got=%h exp=%h", r, ov(), e);
                else n_pass++;
                step();
            end
            k = 0;
            c = 0;
            while (k < 16 && c < 100) begin
                rif.stall_i = ($urandom % 4 == 0);
                #1;
                if (rif.stall_i) e = ev(0, 0, 0, 0, 0, 0, 1);
                else e = ev(1, 4'(k), m_stk[k], k == 15, (k == 15) ? m_tos : 4'd0, 0, 1);
                n_chk++;
                if (ov() !== e) $display("FAIL rand_copy r=%0d k=%0d got=%h exp=%h", r, k, ov(), e);
                else n_pass++;
                if (!rif.stall_i) k++;
                step();
                c++;
            end
            rif.stall_i = 1'b0;
            #1;
            e = ev(0, 0, 0, 0, 0, 1, 1);
            n_chk++;
            if (ov() !== e) $display("FAIL rand_done r=%0d got=%h exp=%h", r, ov(), e);
            else n_pass++;
            step();
        end
    endtask

    initial begin
        n_chk               = 0;
        n_pass              = 0;
        rst                 = 1'b1;
        m_tos               = 4'd0;
        rif.stall_i         = 1'b0;
        rif.commitValid_i   = 1'b0;
        rif.commitCall_i    = 1'b0;
        rif.commitRtr_i     = 1'b0;
        rif.commitPC_i      = 32'd0;
        rif.flagRecoverEX_i = 1'b0;
        for (int i = 0; i < 16; i++) m_stk[i] = 32'd0;
        @(posedge clk);
        #1;
        test_reset();
        test_three_calls();
        test_wrap();
        test_stall();
        test_commit_restart();
        test_recover_in_done();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
